// File: rtl/dbuf_sync_filt_pkg.sv
// Shared constants and types for the dbuf_sync_filt channel buffer.
// Imported by the interface, the per-channel filter and the top.
package dbuf_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Per-channel state at the default configuration: synchroniser vector, counter, filtered output.
  typedef struct packed {
    logic [SYNC_STAGES_DEF-1:0] sync;
    logic [CNT_W_DEF-1:0]       cnt;
    logic                       o;
  } chan_state_t;

  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/dbuf_sync_filt_if.sv
// Core-side channel bus of dbuf_sync_filt: raw inputs and controls in,
// filtered levels, edge pulses and sticky flags out.
interface dbuf_sync_filt_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = dbuf_pkg::CNT_W_DEF
) ();

  logic [N_CH-1:0]  i;
  logic             en;
  logic [CNT_W-1:0] filt_len;
  logic [N_CH-1:0]  evt_clr;
  logic [N_CH-1:0]  o;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  evt;

  modport master (
    output i, en, filt_len, evt_clr,
    input  o, rise, fall, evt
  );

  modport slave (
    input  i, en, filt_len, evt_clr,
    output o, rise, fall, evt
  );

endinterface

// File: rtl/dbuf_sync_filt_chan.sv
// One channel: synchroniser, deglitch filter, edge pulses and sticky edge flag.
// Sticky flag is built only when DBUF_STICKY_EN is defined.
module dbuf_chan
  import dbuf_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             evt_clr,
  output logic             o,
  output logic             rise,
  output logic             fall,
  output logic             evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // The >= compare lets a lowered filt_len take effect on the very next cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i};
    s      = sync_q[SYNC_STAGES-1];
    o_d    = o_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en) begin
      if (s == o_q) begin
        cnt_d = '0;
      end else if (cnt_q >= filt_len) begin
        o_d    = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      o_q    <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      o_q    <= o_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DBUF_STICKY_EN
  logic evt_q, evt_d;

  // A pulse in the same cycle as a clear keeps the flag set.
  always_comb begin
    evt_d = rise_q | fall_q | (evt_q & ~evt_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt = evt_q;
`else
  logic evt_clr_unused;
  assign evt_clr_unused = evt_clr;
  assign evt            = 1'b0;
`endif

endmodule

// File: rtl/dbuf_sync_filt.sv
// N-channel synchronising, deglitching input buffer; one dbuf_chan per channel.
// Optional sticky edge flags are enabled by defining DBUF_STICKY_EN.
module dbuf_sync_filt
  import dbuf_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit RST_VAL     = 1'b0
) (
  input logic            CELCLK,
  input logic            CELRST,
  input logic            CELV,
  input logic            CELG,
  input logic            SUB,
  dbuf_sync_filt_if.slave bus
);

  // Supply pins exist only for netlisting and have no logical effect.
  logic supply_unused;
  assign supply_unused = CELV ^ CELG ^ SUB;

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
    $error("dbuf_sync_filt: SYNC_STAGES must be in 2..4");
  end

  logic [N_CH-1:0] o_vec, rise_vec, fall_vec, evt_vec;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    dbuf_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RST_VAL     (RST_VAL)
    ) u_chan (
      .clk      (CELCLK),
      .rst      (CELRST),
      .i        (bus.i[k]),
      .en       (bus.en),
      .filt_len (bus.filt_len),
      .evt_clr  (bus.evt_clr[k]),
      .o        (o_vec[k]),
      .rise     (rise_vec[k]),
      .fall     (fall_vec[k]),
      .evt      (evt_vec[k])
    );
  end

  assign bus.o    = o_vec;
  assign bus.rise = rise_vec;
  assign bus.fall = fall_vec;
  assign bus.evt  = evt_vec;

endmodule

// File: tb/tb_dbuf_sync_filt.sv
// Directed bench for dbuf_sync_filt (N_CH=4, SYNC_STAGES=2, CNT_W=8, RST_VAL=0).
// Sticky-flag expectations follow DBUF_STICKY_EN.
module tb_dbuf_sync_filt;

`ifdef DBUF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk, rst, celv, celg, sub;
  int   checks, errors;

  dbuf_sync_filt_if #(.N_CH(4), .CNT_W(8)) bus ();

  dbuf_sync_filt #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .RST_VAL     (1'b0)
  ) dut (
    .CELCLK (clk),
    .CELRST (rst),
    .CELV   (celv),
    .CELG   (celg),
    .SUB    (sub),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] sticky_exp(input logic [3:0] v);
    return STICKY ? v : 4'h0;
  endfunction

  initial begin
    logic [3:0] seen;
    checks = 0;
    errors = 0;
    celv = 1'b1; celg = 1'b0; sub = 1'b0;
    rst = 1'b1;
    bus.i = 4'hF; bus.en = 1'b1; bus.filt_len = 8'd0; bus.evt_clr = 4'h0;

    // Reset held with all inputs high
    repeat (2) tick();
    check_output("rst_o", bus.o, 4'h0);
    check_output("rst_rise", bus.rise, 4'h0);
    check_output("rst_fall", bus.fall, 4'h0);
    check_output("rst_evt", bus.evt, 4'h0);
    rst = 1'b0;
    tick();
    check_output("rel_t1_o", bus.o, 4'h0);
    check_output("rel_t1_rise", bus.rise, 4'h0);
    tick();
    check_output("rel_t2_o", bus.o, 4'h0);
    tick();
    check_output("rel_t3_o", bus.o, 4'hF);
    check_output("rel_t3_rise", bus.rise, 4'hF);
    tick();
    check_output("rel_t4_rise", bus.rise, 4'h0);
    check_output("rel_t4_o", bus.o, 4'hF);

    // Drop all channels with filt_len=0
    bus.i = 4'h0;
    repeat (2) tick();
    check_output("drop_t2_o", bus.o, 4'hF);
    tick();
    check_output("drop_t3_o", bus.o, 4'h0);
    check_output("drop_t3_fall", bus.fall, 4'hF);
    tick();
    check_output("drop_t4_fall", bus.fall, 4'h0);

    // 5-cycle glitch on ch0 with filt_len=5 must be rejected
    bus.filt_len = 8'd5;
    bus.i = 4'h1;
    seen = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) bus.i = 4'h0;
      seen = seen | bus.o | bus.rise;
    end
    check_output("glitch_seen", seen, 4'h0);

    // 6-cycle pulse passes: rise at 8, fall at 14
    bus.i = 4'h1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) bus.i = 4'h0;
      if (k == 7) check_output("pass_t7_o", bus.o, 4'h0);
      if (k == 8) begin
        check_output("pass_t8_o", bus.o, 4'h1);
        check_output("pass_t8_rise", bus.rise, 4'h1);
      end
      if (k == 9) check_output("pass_t9_rise", bus.rise, 4'h0);
      if (k == 13) check_output("pass_t13_o", bus.o, 4'h1);
      if (k == 14) begin
        check_output("pass_t14_o", bus.o, 4'h0);
        check_output("pass_t14_fall", bus.fall, 4'h1);
      end
    end

    // Enable freeze while ch1 toggles
    bus.filt_len = 8'd2;
    bus.en = 1'b0;
    seen = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      bus.i = (k <= 3 || k >= 6) ? 4'h2 : 4'h0;
      tick();
      seen = seen | bus.o | bus.rise | bus.fall;
    end
    check_output("freeze_seen", seen, 4'h0);
    bus.en = 1'b1;
    repeat (2) tick();
    check_output("unfreeze_t2_o", bus.o, 4'h0);
    tick();
    check_output("unfreeze_t3_o", bus.o, 4'h2);
    check_output("unfreeze_t3_rise", bus.rise, 4'h2);

    // Lowering filt_len mid-count releases on the next cycle
    bus.filt_len = 8'd200;
    bus.i = 4'hA;
    repeat (12) tick();
    check_output("flen_t12_o", bus.o, 4'h2);
    bus.filt_len = 8'd3;
    tick();
    check_output("flen_t13_o", bus.o, 4'hA);
    check_output("flen_t13_rise", bus.rise, 4'h8);

    // Sticky flags on ch2
    bus.filt_len = 8'd0;
    tick();
    bus.evt_clr = 4'hF;
    tick();
    bus.evt_clr = 4'h0;
    check_output("evt_clear_all", bus.evt, 4'h0);
    bus.i = 4'hE;
    repeat (3) tick();
    check_output("st_rise_o", bus.o, 4'hE);
    check_output("st_rise", bus.rise, 4'h4);
    tick();
    check_output("st_rise_evt", bus.evt, sticky_exp(4'h4));
    bus.evt_clr = 4'h4;
    tick();
    bus.evt_clr = 4'h0;
    check_output("st_clr1_evt", bus.evt, 4'h0);
    bus.i = 4'hA;
    repeat (3) tick();
    check_output("st_fall", bus.fall, 4'h4);
    tick();
    check_output("st_fall_evt", bus.evt, sticky_exp(4'h4));
    repeat (2) tick();
    check_output("st_hold_evt", bus.evt, sticky_exp(4'h4));
    bus.i = 4'hE;
    repeat (3) tick();
    check_output("st_rise2", bus.rise, 4'h4);
    bus.evt_clr = 4'h4;
    tick();
    check_output("st_setwins_evt", bus.evt, sticky_exp(4'h4));
    check_output("st_rise2_once", bus.rise, 4'h0);
    tick();
    bus.evt_clr = 4'h0;
    check_output("st_clr2_evt", bus.evt, 4'h0);

    // Async reset mid-count
    bus.i = 4'hF;
    repeat (3) tick();
    check_output("ar_rise0", bus.rise, 4'h1);
    tick();
    check_output("ar_evt_pre", bus.evt, sticky_exp(4'h1));
    bus.filt_len = 8'd10;
    bus.i = 4'hD;
    repeat (5) tick();
    check_output("ar_pre_o", bus.o, 4'hF);
    #3;
    rst = 1'b1;
    #1;
    check_output("ar_o", bus.o, 4'h0);
    check_output("ar_evt", bus.evt, 4'h0);
    check_output("ar_rise", bus.rise, 4'h0);
    check_output("ar_fall", bus.fall, 4'h0);
    tick();
    rst = 1'b0;
    seen = 4'h0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k <= 3) seen = seen | bus.rise | bus.fall;
      if (k == 12) check_output("ar_t12_o", bus.o, 4'h0);
      if (k == 13) begin
        check_output("ar_t13_o", bus.o, 4'hD);
        check_output("ar_t13_rise", bus.rise, 4'hD);
      end
    end
    check_output("ar_no_pulse", seen, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
